// File: rtl/ber_align.sv
// BER monitor that hunts for the reference delay matching the link latency,
// locks to it, and then accumulates saturating bit and error counts.
`timescale 1ns/1ps

module ber_align #(
    parameter int MAX_DELAY     = 64,
    parameter int WIN_LOG2      = 10,
    parameter int LOCK_THRESH   = 0,
    parameter int UNLOCK_THRESH = 256,
    parameter int CNT_W         = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         sx,
    input  logic                         dx,
    output logic                         o_locked,
    output logic [$clog2(MAX_DELAY)-1:0] o_delay,
    output logic [CNT_W-1:0]             o_bit_count,
    output logic [CNT_W-1:0]             o_err_count,
    output logic                         error_flag
);

    localparam int DW = $clog2(MAX_DELAY);
    localparam int EW = WIN_LOG2 + 1;
    localparam logic [31:0] LOCK_T   = 32'(LOCK_THRESH);
    localparam logic [31:0] UNLOCK_T = 32'(UNLOCK_THRESH);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [MAX_DELAY-2:0]  sr;
    logic [MAX_DELAY-1:0]  taps;
    logic                  err;
    logic                  win_last;
    logic [31:0]           tot;
    logic [WIN_LOG2-1:0]   wcnt;
    logic [WIN_LOG2-1:0]   wcnt_n;
    logic [EW-1:0]         werr;
    logic [EW-1:0]         werr_n;
    logic [DW-1:0]         delay_n;
    logic [CNT_W-1:0]      bit_n;
    logic [CNT_W-1:0]      errc_n;
    logic                  locked_n;
    logic                  flag_n;

    // Tap 0 is the live reference bit; tap d reads the line before it shifts.
    assign taps     = {sr, sx};
    assign err      = dx ^ taps[o_delay];
    assign win_last = &wcnt;
    assign tot      = 32'(werr) + 32'(err);

    // The delay line survives clear so a restarted search sees valid history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr <= '0;
        end else if (enable && !clear) begin
            sr <= {sr[MAX_DELAY-3:0], sx};
        end
    end

    always_comb begin
        state_n  = state;
        delay_n  = o_delay;
        wcnt_n   = wcnt;
        werr_n   = werr;
        bit_n    = o_bit_count;
        errc_n   = o_err_count;
        locked_n = o_locked;
        flag_n   = error_flag;

        if (clear) begin
            state_n  = SEARCH;
            delay_n  = '0;
            wcnt_n   = '0;
            werr_n   = '0;
            bit_n    = '0;
            errc_n   = '0;
            locked_n = 1'b0;
            flag_n   = 1'b1;
        end else if (enable) begin
            wcnt_n = wcnt + WIN_LOG2'(1);
            werr_n = (&werr) ? werr : werr + EW'(err);
            if (win_last) begin
                wcnt_n = '0;
                werr_n = '0;
            end

            if (state == SEARCH) begin
                flag_n = 1'b1;
                if (win_last) begin
                    if (tot <= LOCK_T) begin
                        state_n  = LOCKED;
                        locked_n = 1'b1;
                    end else begin
                        delay_n = o_delay + DW'(1);
                    end
                end
            end else begin
                flag_n = err;
                if (!(&o_bit_count)) begin
                    bit_n = o_bit_count + CNT_W'(1);
                end
                if (err && !(&o_err_count)) begin
                    errc_n = o_err_count + CNT_W'(1);
                end
                // Leaving lock moves straight on to the next candidate delay.
                if (win_last && (tot > UNLOCK_T)) begin
                    state_n  = SEARCH;
                    locked_n = 1'b0;
                    delay_n  = o_delay + DW'(1);
                    flag_n   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SEARCH;
            o_delay     <= '0;
            wcnt        <= '0;
            werr        <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
            o_locked    <= 1'b0;
            error_flag  <= 1'b1;
        end else begin
            state       <= state_n;
            o_delay     <= delay_n;
            wcnt        <= wcnt_n;
            werr        <= werr_n;
            o_bit_count <= bit_n;
            o_err_count <= errc_n;
            o_locked    <= locked_n;
            error_flag  <= flag_n;
        end
    end

endmodule

// File: tb/tb_ber_align.sv
// Bench for ber_align: two instances (default and small saturating counters)
// driven by a PRBS9 stream and checked every cycle against a behavioural model.
`timescale 1ns/1ps

module tb_ber_align;

    localparam int  D0_MAXD = 64;
    localparam int  D0_WLOG = 10;
    localparam int  D0_LOCK = 0;
    localparam int  D0_UNLK = 256;
    localparam int  D0_CW   = 32;
    localparam int  D1_MAXD = 8;
    localparam int  D1_WLOG = 4;
    localparam int  D1_LOCK = 0;
    localparam int  D1_UNLK = 1024;
    localparam int  D1_CW   = 4;

    localparam int     P_MAXD   [2] = '{D0_MAXD, D1_MAXD};
    localparam int     P_WIN    [2] = '{1 << D0_WLOG, 1 << D1_WLOG};
    localparam int     P_LOCK   [2] = '{D0_LOCK, D1_LOCK};
    localparam int     P_UNLOCK [2] = '{D0_UNLK, D1_UNLK};
    localparam longint P_CMAX   [2] = '{64'hFFFF_FFFF, 64'd15};

    logic clk = 1'b0;
    logic rst, enable, clear, sx, dx;

    logic              locked0, flag0;
    logic [5:0]        delay0;
    logic [D0_CW-1:0]  bits0, errs0;
    logic              locked1, flag1;
    logic [2:0]        delay1;
    logic [D1_CW-1:0]  bits1, errs1;

    always #5 clk = ~clk;

    ber_align #(.MAX_DELAY(D0_MAXD), .WIN_LOG2(D0_WLOG), .LOCK_THRESH(D0_LOCK),
                .UNLOCK_THRESH(D0_UNLK), .CNT_W(D0_CW)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .sx(sx), .dx(dx),
        .o_locked(locked0), .o_delay(delay0), .o_bit_count(bits0),
        .o_err_count(errs0), .error_flag(flag0)
    );

    ber_align #(.MAX_DELAY(D1_MAXD), .WIN_LOG2(D1_WLOG), .LOCK_THRESH(D1_LOCK),
                .UNLOCK_THRESH(D1_UNLK), .CNT_W(D1_CW)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .sx(sx), .dx(dx),
        .o_locked(locked1), .o_delay(delay1), .o_bit_count(bits1),
        .o_err_count(errs1), .error_flag(flag1)
    );

    typedef struct {
        int     locked;
        int     delay;
        int     wcnt;
        int     werr;
        longint bits;
        longint errs;
        int     flag;
    } model_t;

    model_t   mdl [2];
    bit       hist [$];
    bit       shist [$];
    logic [8:0] prbs = 9'h1AA;
    int       n_checks = 0;
    int       n_errors = 0;

    function automatic void zeroModel(input int i);
        mdl[i].locked = 0;
        mdl[i].delay  = 0;
        mdl[i].wcnt   = 0;
        mdl[i].werr   = 0;
        mdl[i].bits   = 0;
        mdl[i].errs   = 0;
        mdl[i].flag   = 1;
    endfunction

    function automatic bit refTap(input int d, input bit s);
        if (d == 0) return s;
        if (hist.size() >= d) return hist[hist.size() - d];
        return 1'b0;
    endfunction

    function automatic bit stimTap(input int k, input bit s);
        if (k == 0) return s;
        if (shist.size() >= k) return shist[shist.size() - k];
        return 1'b0;
    endfunction

    // Window-level reference: counts mismatches per window of sampled bits.
    function automatic void modelStep(input bit rstn, input bit clr, input bit en,
                                      input bit s, input bit d);
        bit e;
        int tot;
        if (!rstn) begin
            for (int i = 0; i < 2; i++) zeroModel(i);
            hist.delete();
            return;
        end
        if (clr) begin
            for (int i = 0; i < 2; i++) zeroModel(i);
            return;
        end
        if (!en) return;
        for (int i = 0; i < 2; i++) begin
            e   = d ^ refTap(mdl[i].delay, s);
            tot = mdl[i].werr + int'(e);
            if (mdl[i].locked != 0) begin
                if (mdl[i].bits < P_CMAX[i]) mdl[i].bits++;
                if (e && mdl[i].errs < P_CMAX[i]) mdl[i].errs++;
                mdl[i].flag = int'(e);
            end
            if (mdl[i].wcnt == P_WIN[i] - 1) begin
                mdl[i].wcnt = 0;
                mdl[i].werr = 0;
                if (mdl[i].locked == 0) begin
                    if (tot <= P_LOCK[i]) mdl[i].locked = 1;
                    else mdl[i].delay = (mdl[i].delay + 1) % P_MAXD[i];
                end else if (tot > P_UNLOCK[i]) begin
                    mdl[i].locked = 0;
                    mdl[i].delay  = (mdl[i].delay + 1) % P_MAXD[i];
                    mdl[i].flag   = 1;
                end
            end else begin
                mdl[i].wcnt++;
                mdl[i].werr = tot;
            end
        end
        hist.push_back(s);
        if (hist.size() > 64) void'(hist.pop_front());
    endfunction

    function automatic bit nextPrbs();
        bit b;
        b    = prbs[8] ^ prbs[4];
        prbs = {prbs[7:0], b};
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("d0.locked", 64'(locked0), 64'(mdl[0].locked));
        checkOutput("d0.delay",  64'(delay0),  64'(mdl[0].delay));
        checkOutput("d0.bits",   64'(bits0),   64'(mdl[0].bits));
        checkOutput("d0.errs",   64'(errs0),   64'(mdl[0].errs));
        checkOutput("d0.flag",   64'(flag0),   64'(mdl[0].flag));
        checkOutput("d1.locked", 64'(locked1), 64'(mdl[1].locked));
        checkOutput("d1.delay",  64'(delay1),  64'(mdl[1].delay));
        checkOutput("d1.bits",   64'(bits1),   64'(mdl[1].bits));
        checkOutput("d1.errs",   64'(errs1),   64'(mdl[1].errs));
        checkOutput("d1.flag",   64'(flag1),   64'(mdl[1].flag));
    endtask

    task automatic applyStimulus(input logic en, input logic clr, input logic rstn,
                                 input logic s, input logic d, input bit glitch);
        enable = en;
        clear  = clr;
        rst    = rstn;
        sx     = s;
        dx     = d;
        if (glitch) begin
            #2 rst = 1'b0;
            #2 rst = 1'b1;
        end
        @(posedge clk);
        modelStep(rstn, clr, en, s, d);
        #1 checkAll();
    endtask

    task automatic sendEnable(input int k, input bit inv, input bit glitch);
        bit s, d;
        s = nextPrbs();
        d = stimTap(k, s) ^ inv;
        applyStimulus(1'b1, 1'b0, 1'b1, s, d, glitch);
        shist.push_back(s);
        if (shist.size() > 64) void'(shist.pop_front());
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".locked"}, 64'(locked0), 64'd0);
        checkOutput({tag, ".delay"},  64'(delay0),  64'd0);
        checkOutput({tag, ".bits"},   64'(bits0),   64'd0);
        checkOutput({tag, ".errs"},   64'(errs0),   64'd0);
        checkOutput({tag, ".flag"},   64'(flag0),   64'd1);
    endtask

    initial begin
        longint b_start, e_start, hold_bits;
        int     n, k, r;

        for (int i = 0; i < 2; i++) zeroModel(i);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCleared("reset");

        $display("[TB] strobed search, dx delayed by 5");
        for (int i = 1; i <= 6144; i++) begin
            repeat (3) idleCycle();
            sendEnable(5, 1'b0, 1'b0);
            if (i == 6143) checkOutput("a.prelock", 64'(locked0), 64'd0);
        end
        checkOutput("a.locked", 64'(locked0), 64'd1);
        checkOutput("a.delay", 64'(delay0), 64'd5);
        checkOutput("a.flag_at_lock", 64'(flag0), 64'd1);
        repeat (3) idleCycle();
        sendEnable(5, 1'b0, 1'b0);
        checkOutput("a.flag_after", 64'(flag0), 64'd0);
        checkOutput("a.d1_locked", 64'(locked1), 64'd1);
        checkOutput("a.d1_bits_sat", 64'(bits1), 64'd15);

        $display("[TB] injected errors every 100th bit");
        b_start = longint'(bits0);
        e_start = longint'(errs0);
        for (int i = 0; i < 10000; i++) begin
            sendEnable(5, (i % 100) == 99, 1'b0);
            if (i == 99)  checkOutput("b.flag_err", 64'(flag0), 64'd1);
            if (i == 100) checkOutput("b.flag_ok", 64'(flag0), 64'd0);
        end
        checkOutput("b.bits", 64'(longint'(bits0) - b_start), 64'd10000);
        checkOutput("b.errs", 64'(longint'(errs0) - e_start), 64'd100);
        checkOutput("b.locked", 64'(locked0), 64'd1);
        checkOutput("b.d1_errs_sat", 64'(errs1), 64'd15);
        checkOutput("b.d1_locked", 64'(locked1), 64'd1);

        $display("[TB] latency change to 9");
        for (n = 0; n < 4096 && locked0; n++) sendEnable(9, 1'b0, 1'b0);
        checkOutput("c.unlocked", 64'(locked0), 64'd0);
        checkOutput("c.delay_next", 64'(delay0), 64'd6);
        hold_bits = longint'(bits0);
        for (n = 0; n < 6 * 1024 && !locked0; n++) sendEnable(9, 1'b0, 1'b0);
        checkOutput("c.relocked", 64'(locked0), 64'd1);
        checkOutput("c.delay_relock", 64'(delay0), 64'd9);
        checkOutput("c.bits_held", 64'(bits0), 64'(hold_bits));

        $display("[TB] clear during search");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCleared("d.clear1");
        for (int i = 0; i < 3 * 1024 + 500; i++) sendEnable(5, 1'b0, 1'b0);
        checkOutput("d.mid_delay", 64'(delay0), 64'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkCleared("d.clear2");
        for (int i = 0; i < 6144; i++) sendEnable(5, 1'b0, 1'b0);
        checkOutput("d.relocked", 64'(locked0), 64'd1);
        checkOutput("d.delay", 64'(delay0), 64'd5);

        $display("[TB] reset while locked");
        repeat (50) sendEnable(5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
        checkCleared("e.reset");
        checkOutput("e.d1_locked", 64'(locked1), 64'd0);
        sendEnable(5, 1'b0, 1'b1);
        for (int i = 1; i < 6144; i++) sendEnable(5, 1'b0, 1'b0);
        checkOutput("e.relocked", 64'(locked0), 64'd1);
        checkOutput("e.delay", 64'(delay0), 64'd5);

        $display("[TB] randomized traffic");
        k = 5;
        for (int i = 0; i < 10000; i++) begin
            if (i % 1500 == 0) k = $urandom_range(0, 12);
            r = $urandom_range(0, 2999);
            if (r == 0)
                applyStimulus(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            else if (r < 4)
                applyStimulus(1'($urandom), 1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b0);
            else if ($urandom_range(0, 2) != 0)
                sendEnable(k, $urandom_range(0, 63) == 0, $urandom_range(0, 99) == 0);
            else
                idleCycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
